// File: rtl/mcu_block_scheduler.sv
// mcu_block_scheduler: walks the MCUs of one scan in raster order and issues one block
// descriptor at a time to the entropy decoder. Restart-marker handling is built only with RST_INTERVAL_EN.
module mcu_block_scheduler #(
    parameter int DIM_W = 16,
    parameter int RST_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_scan,
    input  logic             abort,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic [1:0]       num_components,
    input  logic [1:0]       samp_mode,
    input  logic [RST_W-1:0] restart_interval,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_comp,
    output logic             cmd_qtbl,
    output logic             cmd_htbl,
    output logic [2:0]       cmd_blk_idx,
    output logic [DIM_W-1:0] mcu_x,
    output logic [DIM_W-1:0] mcu_y,
    input  logic             blk_done,
    output logic             dc_pred_clr,
    output logic             rst_expect,
    input  logic             rst_seen,
    output logic             busy,
    output logic             scan_done,
    output logic             cfg_err,
    output logic             proto_err
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_CALC, ST_ISSUE, ST_WAIT_DONE, ST_NEXT, ST_DONE
`ifdef RST_INTERVAL_EN
        , ST_RST_WAIT
`endif
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIM_W-1:0] r_w, r_h, r_mcus_x, r_mcus_y, r_mcu_x, r_mcu_y;
    logic             r_h2, r_v2;
    logic [2:0]       r_bpm, r_blk_idx;
    logic             r_dc_clr, r_cfg_err, r_proto_err;
    logic [DIM_W:0]   w_sx, w_sy;
    logic [DIM_W-1:0] w_mcus_x, w_mcus_y;
    logic             w_grid_zero, w_blk_last, w_mcu_last_x, w_mcu_last;
    logic [1:0]       w_comp;
    logic             w_unused;

    // Extra top bit keeps w+15 from overflowing at the maximum dimension.
    assign w_sx = {1'b0, r_w} + (DIM_W+1)'(r_h2 ? 15 : 7);
    assign w_sy = {1'b0, r_h} + (DIM_W+1)'(r_v2 ? 15 : 7);
    assign w_mcus_x = r_h2 ? {3'b000, w_sx[DIM_W:4]} : {2'b00, w_sx[DIM_W:3]};
    assign w_mcus_y = r_v2 ? {3'b000, w_sy[DIM_W:4]} : {2'b00, w_sy[DIM_W:3]};
    assign w_grid_zero  = (w_mcus_x == '0) || (w_mcus_y == '0);
    assign w_blk_last   = (r_blk_idx == r_bpm - 3'd1);
    assign w_mcu_last_x = (r_mcu_x == r_mcus_x - DIM_W'(1));
    assign w_mcu_last   = w_mcu_last_x && (r_mcu_y == r_mcus_y - DIM_W'(1));

`ifdef RST_INTERVAL_EN
    logic [RST_W-1:0] r_rst_int, r_rst_cnt, w_rst_cnt_inc;
    logic             w_rst_hit;
    assign w_rst_cnt_inc = r_rst_cnt + RST_W'(1);
    assign w_rst_hit     = (r_rst_int != '0) && (w_rst_cnt_inc == r_rst_int);
    assign w_unused      = ^{w_sx[2:0], w_sy[2:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rst_int <= '0;
            r_rst_cnt <= '0;
        end else if (!abort) begin
            if (r_state == ST_IDLE && start_scan) begin
                r_rst_int <= restart_interval;
                r_rst_cnt <= '0;
            end else if (r_state == ST_NEXT) begin
                r_rst_cnt <= w_rst_cnt_inc;
            end else if (r_state == ST_RST_WAIT && rst_seen) begin
                r_rst_cnt <= '0;
            end
        end
    end
`else
    assign w_unused = ^{w_sx[2:0], w_sy[2:0], restart_interval, rst_seen};
`endif

    // Luma blocks come first in every MCU, then one Cb and one Cr.
    always_comb begin
        w_comp = 2'd0;
        case (r_bpm)
            3'd3:    w_comp = r_blk_idx[1:0];
            3'd4:    if (r_blk_idx >= 3'd2) w_comp = r_blk_idx[1:0] - 2'd1;
            3'd6:    if (r_blk_idx >= 3'd4) w_comp = r_blk_idx[1:0] + 2'd1;
            default: w_comp = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      if (start_scan) w_state_nxt = ST_CALC;
                ST_CALC:      w_state_nxt = w_grid_zero ? ST_DONE : ST_ISSUE;
                ST_ISSUE:     if (cmd_ready) w_state_nxt = ST_WAIT_DONE;
                ST_WAIT_DONE: if (blk_done) w_state_nxt = w_blk_last ? ST_NEXT : ST_ISSUE;
                ST_NEXT: begin
                    if (w_mcu_last)     w_state_nxt = ST_DONE;
`ifdef RST_INTERVAL_EN
                    else if (w_rst_hit) w_state_nxt = ST_RST_WAIT;
`endif
                    else                w_state_nxt = ST_ISSUE;
                end
`ifdef RST_INTERVAL_EN
                ST_RST_WAIT:  if (rst_seen) w_state_nxt = ST_ISSUE;
`endif
                ST_DONE:      w_state_nxt = ST_IDLE;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_valid  = (r_state == ST_ISSUE);
        busy       = (r_state != ST_IDLE);
        scan_done  = (r_state == ST_DONE);
`ifdef RST_INTERVAL_EN
        rst_expect = (r_state == ST_RST_WAIT);
`else
        rst_expect = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w <= '0; r_h <= '0; r_mcus_x <= '0; r_mcus_y <= '0;
            r_mcu_x <= '0; r_mcu_y <= '0; r_h2 <= 1'b0; r_v2 <= 1'b0;
            r_bpm <= '0; r_blk_idx <= '0;
            r_dc_clr <= 1'b0; r_cfg_err <= 1'b0; r_proto_err <= 1'b0;
        end else begin
            r_dc_clr <= 1'b0;
            if (!abort) begin
                case (r_state)
                    ST_IDLE: if (start_scan) begin
                        r_w         <= img_width;
                        r_h         <= img_height;
                        r_h2        <= (num_components != 2'd1) && (samp_mode == 2'd1 || samp_mode == 2'd2);
                        r_v2        <= (num_components != 2'd1) && (samp_mode == 2'd2);
                        r_bpm       <= (num_components == 2'd1) ? 3'd1 :
                                       (samp_mode == 2'd1)      ? 3'd4 :
                                       (samp_mode == 2'd2)      ? 3'd6 : 3'd3;
                        r_blk_idx   <= '0;
                        r_mcu_x     <= '0;
                        r_mcu_y     <= '0;
                        r_cfg_err   <= 1'b0;
                        r_proto_err <= 1'b0;
                        r_dc_clr    <= 1'b1;
                    end
                    ST_CALC: begin
                        r_mcus_x <= w_mcus_x;
                        r_mcus_y <= w_mcus_y;
                        if (w_grid_zero) r_cfg_err <= 1'b1;
                    end
                    ST_WAIT_DONE: if (blk_done) r_blk_idx <= w_blk_last ? 3'd0 : r_blk_idx + 3'd1;
                    ST_NEXT: if (!w_mcu_last) begin
                        r_mcu_x <= w_mcu_last_x ? '0 : r_mcu_x + DIM_W'(1);
                        if (w_mcu_last_x) r_mcu_y <= r_mcu_y + DIM_W'(1);
                    end
`ifdef RST_INTERVAL_EN
                    ST_RST_WAIT: if (rst_seen) r_dc_clr <= 1'b1;
`endif
                    default: ;
                endcase
                if (blk_done && r_state != ST_WAIT_DONE) r_proto_err <= 1'b1;
            end
        end
    end

    assign cmd_comp    = w_comp;
    assign cmd_qtbl    = (w_comp != 2'd0);
    assign cmd_htbl    = (w_comp != 2'd0);
    assign cmd_blk_idx = r_blk_idx;
    assign mcu_x       = r_mcu_x;
    assign mcu_y       = r_mcu_y;
    assign dc_pred_clr = r_dc_clr;
    assign cfg_err     = r_cfg_err;
    assign proto_err   = r_proto_err;
endmodule

// File: tb/tb_mcu_block_scheduler.sv
// Directed bench for mcu_block_scheduler: a queue model of the expected descriptor stream,
// a per-cycle compare process, and literal expectations for the key scans.
module tb_mcu_block_scheduler;
    localparam int DIM_W = 16;
    localparam int RST_W = 16;
`ifdef RST_INTERVAL_EN
    localparam bit RST_ON = 1'b1;
`else
    localparam bit RST_ON = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start_scan = 1'b0, abort = 1'b0;
    logic [DIM_W-1:0] img_width = '0, img_height = '0;
    logic [1:0] num_components = 2'd1, samp_mode = 2'd0;
    logic [RST_W-1:0] restart_interval = '0;
    logic cmd_valid, cmd_ready = 1'b0, cmd_qtbl, cmd_htbl;
    logic [1:0] cmd_comp;
    logic [2:0] cmd_blk_idx;
    logic [DIM_W-1:0] mcu_x, mcu_y;
    logic blk_done = 1'b0, dc_pred_clr, rst_expect, rst_seen = 1'b0;
    logic busy, scan_done, cfg_err, proto_err;

    always #5 clk = ~clk;

    mcu_block_scheduler #(.DIM_W(DIM_W), .RST_W(RST_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_scan(start_scan), .abort(abort),
        .img_width(img_width), .img_height(img_height), .num_components(num_components),
        .samp_mode(samp_mode), .restart_interval(restart_interval),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_comp(cmd_comp),
        .cmd_qtbl(cmd_qtbl), .cmd_htbl(cmd_htbl), .cmd_blk_idx(cmd_blk_idx),
        .mcu_x(mcu_x), .mcu_y(mcu_y), .blk_done(blk_done), .dc_pred_clr(dc_pred_clr),
        .rst_expect(rst_expect), .rst_seen(rst_seen), .busy(busy), .scan_done(scan_done),
        .cfg_err(cfg_err), .proto_err(proto_err)
    );

    typedef struct { int comp; int x; int y; int idx; } desc_t;
    desc_t exp_q[$];
    desc_t seen[$];
    int    seen_q[$];
    int    checks = 0, errors = 0;
    int    n_dc = 0, n_done = 0;
    bit    chk_en = 1'b0, mdl_rst_win = 1'b0, p_stall = 1'b0;
    desc_t p_d;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of the scan geometry taken straight from the block/MCU rules.
    function automatic int gmx(input int w, input int nc, input int sm);
        bit h2 = (nc != 1) && (sm == 1 || sm == 2);
        return h2 ? (w + 15) / 16 : (w + 7) / 8;
    endfunction
    function automatic int gmy(input int h, input int nc, input int sm);
        bit v2 = (nc != 1) && (sm == 2);
        return v2 ? (h + 15) / 16 : (h + 7) / 8;
    endfunction
    function automatic int gbpm(input int nc, input int sm);
        if (nc == 1) return 1;
        if (sm == 1) return 4;
        if (sm == 2) return 6;
        return 3;
    endfunction
    function automatic int comp_of(input int bpm, input int b);
        int ny = (bpm == 1) ? 1 : bpm - 2;
        return (b < ny) ? 0 : b - ny + 1;
    endfunction

    always @(negedge clk) begin
        if (dc_pred_clr) n_dc++;
        if (scan_done) n_done++;
        if (chk_en) begin
            chk("rst_expect", int'(rst_expect), int'(mdl_rst_win));
            if (cmd_valid) begin
                if (exp_q.size() == 0) chk("unexpected_cmd", 1, 0);
                else begin
                    chk("cmd_comp", int'(cmd_comp), exp_q[0].comp);
                    chk("cmd_qtbl", int'(cmd_qtbl), int'(exp_q[0].comp != 0));
                    chk("cmd_htbl", int'(cmd_htbl), int'(exp_q[0].comp != 0));
                    chk("cmd_blk_idx", int'(cmd_blk_idx), exp_q[0].idx);
                    chk("mcu_x", int'(mcu_x), exp_q[0].x);
                    chk("mcu_y", int'(mcu_y), exp_q[0].y);
                end
            end
            if (p_stall) begin
                chk("stall_valid", int'(cmd_valid), 1);
                chk("stall_comp", int'(cmd_comp), p_d.comp);
                chk("stall_idx", int'(cmd_blk_idx), p_d.idx);
                chk("stall_x", int'(mcu_x), p_d.x);
                chk("stall_y", int'(mcu_y), p_d.y);
            end
        end
        p_stall = chk_en && cmd_valid && !cmd_ready;
        p_d = '{int'(cmd_comp), int'(mcu_x), int'(mcu_y), int'(cmd_blk_idx)};
    end

    task automatic run_scan(input int w, input int h, input int nc, input int sm, input int ri,
                            input int lag, input bit inject, input int exp_dc);
        int mx, my, bpm, nm, k;
        bit to, rst_hit;
        mx = gmx(w, nc, sm); my = gmy(h, nc, sm); bpm = gbpm(nc, sm); nm = mx * my;
        exp_q.delete(); seen.delete(); seen_q.delete();
        for (int y = 0; y < my; y++)
            for (int x = 0; x < mx; x++)
                for (int b = 0; b < bpm; b++) exp_q.push_back('{comp_of(bpm, b), x, y, b});
        n_dc = 0; n_done = 0; to = 1'b0;
        img_width = DIM_W'(w); img_height = DIM_W'(h);
        num_components = 2'(nc); samp_mode = 2'(sm); restart_interval = RST_W'(ri);
        start_scan = 1'b1; tick(); start_scan = 1'b0;
        chk_en = 1'b1;
        chk("start_busy", int'(busy), 1);
        chk("start_proto_clr", int'(proto_err), 0);
        for (int m = 0; m < nm; m++) begin
            for (int b = 0; b < bpm; b++) begin
                k = 0;
                while (!cmd_valid && k < 20) begin tick(); k++; end
                if (!cmd_valid) begin chk("cmd_timeout", 0, 1); to = 1'b1; break; end
                for (int i = 0; i < lag; i++) begin
                    if (inject && i == 1) blk_done = 1'b1;
                    tick();
                    blk_done = 1'b0;
                end
                seen.push_back('{int'(cmd_comp), int'(mcu_x), int'(mcu_y), int'(cmd_blk_idx)});
                seen_q.push_back(int'(cmd_qtbl));
                cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
                void'(exp_q.pop_front());
                chk("wait_no_valid", int'(cmd_valid), 0);
                repeat (2) tick();
                blk_done = 1'b1; tick(); blk_done = 1'b0;
                if (b < bpm - 1) chk("lat_in_mcu", int'(cmd_valid), 1);
                else begin
                    chk("lat_mcu_edge", int'(cmd_valid), 0);
                    tick();
                    rst_hit = RST_ON && ri != 0 && ((m + 1) % ri == 0) && (m + 1 < nm);
                    if (m + 1 == nm) chk("done_pulse", int'(scan_done), 1);
                    else if (rst_hit) begin
                        mdl_rst_win = 1'b1;
                        chk("rst_expect_level", int'(rst_expect), 1);
                        repeat (10) begin tick(); chk("rst_hold_no_valid", int'(cmd_valid), 0); end
                        rst_seen = 1'b1; tick(); rst_seen = 1'b0;
                        mdl_rst_win = 1'b0;
                        chk("after_rst_valid", int'(cmd_valid), 1);
                    end else chk("lat_cross_mcu", int'(cmd_valid), 1);
                end
            end
            if (to) break;
        end
        repeat (3) tick();
        chk_en = 1'b0;
        chk("scan_done_count", n_done, 1);
        chk("end_busy", int'(busy), 0);
        chk("model_drained", exp_q.size(), 0);
        chk("dc_clr_count", n_dc, exp_dc);
        chk("proto_err", int'(proto_err), int'(inject));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_c[6];
        exp_c = '{0, 0, 0, 0, 1, 2};
        repeat (3) tick();
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_scan_done", int'(scan_done), 0);
        chk("rst_dc_clr", int'(dc_pred_clr), 0);
        chk("rst_errs", int'({cfg_err, proto_err, rst_expect}), 0);
        chk("rst_pos", int'(mcu_x) + int'(mcu_y) + int'(cmd_blk_idx) + int'(cmd_comp), 0);
        rst_n = 1'b1; tick();

        // Pin the model itself.
        chk("mdl_17x9_mx", gmx(17, 3, 0), 3);
        chk("mdl_17x9_my", gmy(9, 3, 0), 2);
        chk("mdl_24x8_mx", gmx(24, 1, 2), 3);
        chk("mdl_ffff_mx", gmx(65535, 3, 2), 4096);

        // 16x16 4:2:0, one MCU of six blocks.
        run_scan(16, 16, 3, 2, 0, 1, 1'b0, 1);
        chk("t1_ncmd", seen.size(), 6);
        for (int i = 0; i < 6 && i < seen.size(); i++) begin
            chk("t1_comp_seq", seen[i].comp, exp_c[i]);
            chk("t1_qtbl_seq", seen_q[i], (i < 4) ? 0 : 1);
        end

        // 24x8 grayscale, three MCUs in a row.
        run_scan(24, 8, 1, 0, 0, 1, 1'b0, 1);
        chk("t2_ncmd", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            chk("t2_mcu_x", seen[i].x, i);
            chk("t2_comp", seen[i].comp, 0);
        end

        // 17x9 4:4:4, row wrap after mcu_x=2.
        run_scan(17, 9, 3, 0, 0, 1, 1'b0, 1);
        chk("t3_ncmd", seen.size(), 18);
        if (seen.size() == 18) begin
            chk("t3_last_row0_x", seen[8].x, 2);
            chk("t3_last_row0_y", seen[8].y, 0);
            chk("t3_first_row1_x", seen[9].x, 0);
            chk("t3_first_row1_y", seen[9].y, 1);
        end

        // 32x16 4:2:0 with restart after every MCU.
        run_scan(32, 16, 3, 2, 1, 1, 1'b0, RST_ON ? 2 : 1);
        chk("t4_ncmd", seen.size(), 12);

        // Stall for 5 cycles and a stray blk_done while issuing.
        run_scan(16, 16, 3, 2, 0, 5, 1'b1, 1);
        chk("t5_ncmd", seen.size(), 6);

        // Zero width: config error, scan_done two cycles after start.
        n_done = 0;
        img_width = '0; img_height = DIM_W'(16); num_components = 2'd3; samp_mode = 2'd0;
        start_scan = 1'b1; tick(); start_scan = 1'b0;
        chk("t6_calc_valid", int'(cmd_valid), 0);
        chk("t6_proto_clr", int'(proto_err), 0);
        tick();
        chk("t6_scan_done", int'(scan_done), 1);
        chk("t6_cfg_err", int'(cfg_err), 1);
        chk("t6_no_valid", int'(cmd_valid), 0);
        tick();
        chk("t6_idle", int'(busy), 0);
        chk("t6_cfg_sticky", int'(cfg_err), 1);
        chk("t6_done_count", n_done, 1);

        // Abort in the middle of an MCU.
        n_done = 0;
        img_width = DIM_W'(16); samp_mode = 2'd2;
        start_scan = 1'b1; tick(); start_scan = 1'b0;
        chk("t7_cfg_clr", int'(cfg_err), 0);
        tick();
        chk("t7_issue", int'(cmd_valid), 1);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        blk_done = 1'b1; tick(); blk_done = 1'b0;
        chk("t7_second_blk", int'(cmd_blk_idx), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t7_busy", int'(busy), 0);
        chk("t7_valid", int'(cmd_valid), 0);
        chk("t7_rst_expect", int'(rst_expect), 0);
        repeat (3) tick();
        chk("t7_no_done", n_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
